// File: rtl/dl_word_packer.sv
// Download byte-to-word packer: pairs download bytes into 16-bit words,
// buffers them in a small FIFO and issues them to SDRAM over req/ack.
module dl_word_packer #(
    parameter int unsigned FIFO_AW    = 2,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [23:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_be,
    output logic        dl_busy,
    output logic        dl_done,
    output logic        overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } word_t;

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t             state;
    word_t              pend;
    word_t              pend_n;
    word_t              in_word;
    word_t              push_word;
    word_t              fifo_mem [DEPTH];
    logic               pend_valid;
    logic               pend_valid_n;
    logic               push_c;
    logic               pop_c;
    logic               wr_en;
    logic               dl_prev;
    logic               dl_rise;
    logic               dl_fall;
    logic               dl_armed;
    logic               fifo_empty;
    logic               fifo_full;
    logic               lane;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CW-1:0]      count;

    assign dl_rise    = ioctl_download & ~dl_prev;
    assign dl_fall    = ~ioctl_download & dl_prev;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));
    assign pop_c      = (state == ST_IDLE) & ~fifo_empty;
    // A push into a full FIFO only lands if the head leaves in the same cycle
    assign wr_en      = push_c & (~fifo_full | pop_c);
    assign lane       = ioctl_addr[0] ^ BIG_ENDIAN;

    // Pending-slot merge/flush decision and the single FIFO push per cycle
    always_comb begin
        in_word      = '0;
        in_word.addr = ioctl_addr[24:1];
        if (lane) begin
            in_word.data[15:8] = ioctl_dout;
            in_word.be         = 2'b10;
        end else begin
            in_word.data[7:0]  = ioctl_dout;
            in_word.be         = 2'b01;
        end

        pend_n       = pend;
        pend_valid_n = pend_valid & ~dl_rise;
        push_c       = 1'b0;
        push_word    = pend;

        if (ioctl_wr) begin
            if (pend_valid_n && (pend.addr == in_word.addr) && ((pend.be & in_word.be) == 2'b00)) begin
                pend_n.data = pend.data | in_word.data;
                pend_n.be   = pend.be | in_word.be;
                if (pend_n.be == 2'b11) begin
                    push_c       = 1'b1;
                    push_word    = pend_n;
                    pend_valid_n = 1'b0;
                end
            end else begin
                push_c       = pend_valid_n;
                pend_n       = in_word;
                pend_valid_n = 1'b1;
            end
        end else if (dl_fall && pend_valid) begin
            push_c       = 1'b1;
            pend_valid_n = 1'b0;
        end
    end

    // FIFO storage (no reset needed, validity tracked by count)
    always_ff @(posedge clk_sys) begin
        if (wr_en) begin
            fifo_mem[wr_ptr] <= push_word;
        end
    end

    // Pending slot, FIFO pointers, download edge tracking and overflow flag
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pend       <= '0;
            pend_valid <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dl_prev    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            pend       <= pend_n;
            pend_valid <= pend_valid_n;
            dl_prev    <= ioctl_download;
            if (wr_en) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({wr_en, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_c && !wr_en) begin
                overflow <= 1'b1;
            end else if (dl_rise) begin
                overflow <= 1'b0;
            end
        end
    end

    // Output request FSM: one word in flight, req dropped for a cycle between words
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_be   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        mem_addr <= fifo_mem[rd_ptr].addr;
                        mem_din  <= fifo_mem[rd_ptr].data;
                        mem_be   <= fifo_mem[rd_ptr].be;
                        mem_req  <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Busy status and single completion pulse once a finished download has drained
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_busy  <= 1'b0;
            dl_done  <= 1'b0;
            dl_armed <= 1'b0;
        end else begin
            dl_busy <= ioctl_download | pend_valid | ~fifo_empty | mem_req;
            dl_done <= 1'b0;
            if (dl_rise) begin
                dl_armed <= 1'b0;
            end else if (dl_fall) begin
                dl_armed <= 1'b1;
            end else if (dl_armed && !ioctl_download && !pend_valid && fifo_empty && !push_c && !mem_req) begin
                dl_done  <= 1'b1;
                dl_armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dl_word_packer.sv
// Bench for dl_word_packer: directed scenarios plus random downloads against a byte-level model.
module tb_dl_word_packer;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [23:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_be;
    logic        dl_busy;
    logic        dl_done;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit ack_en = 1'b1;
    int ack_dly = 2;

    logic [41:0] exp_q[$];
    logic [41:0] got_q[$];

    // reference model: the currently open word, built from bytes
    bit         m_valid = 1'b0;
    int         m_waddr = 0;
    bit         m_have[2];
    logic [7:0] m_byte[2];

    dl_word_packer dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_be         (mem_be),
        .dl_busy        (dl_busy),
        .dl_done        (dl_done),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic void m_emit();
        logic [15:0] d;
        logic [1:0]  be;
        d  = {m_have[1] ? m_byte[1] : 8'h00, m_have[0] ? m_byte[0] : 8'h00};
        be = {m_have[1], m_have[0]};
        exp_q.push_back({24'(m_waddr), d, be});
        m_valid   = 1'b0;
        m_have[0] = 1'b0;
        m_have[1] = 1'b0;
    endfunction

    // a byte joins the open word if it has the same word address and a free lane
    function automatic void m_byte_in(input int addr, input logic [7:0] b);
        int w;
        int l;
        w = addr / 2;
        l = addr % 2;
        if (m_valid && w == m_waddr && !m_have[l]) begin
            m_have[l] = 1'b1;
            m_byte[l] = b;
            if (m_have[0] && m_have[1]) m_emit();
        end else begin
            if (m_valid) m_emit();
            m_have[0] = 1'b0;
            m_have[1] = 1'b0;
            m_valid   = 1'b1;
            m_waddr   = w;
            m_have[l] = 1'b1;
            m_byte[l] = b;
        end
    endfunction

    task automatic send_byte(input int addr, input logic [7:0] b, input int gap);
        @(negedge clk_sys);
        ioctl_addr = 25'(addr);
        ioctl_dout = b;
        ioctl_wr   = 1'b1;
        m_byte_in(addr, b);
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        repeat (gap) @(negedge clk_sys);
    endtask

    task automatic dl_start();
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        m_valid   = 1'b0;
        m_have[0] = 1'b0;
        m_have[1] = 1'b0;
        done_cnt  = 0;
    endtask

    task automatic dl_end();
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        if (m_valid) m_emit();
    endtask

    task automatic wait_got(input string tag, input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 2000) begin
            @(negedge clk_sys);
            t++;
        end
        chk({tag, "_wait"}, 64'(t < 2000), 64'(1));
    endtask

    task automatic drain(input string tag);
        wait_got(tag, exp_q.size());
        repeat (12) @(negedge clk_sys);
        chk({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // SDRAM controller stand-in: captures each request, checks it stays stable, acks after ack_dly
    initial begin : responder
        bit          busy;
        int          wcnt;
        logic [41:0] held;
        busy = 1'b0;
        wcnt = 0;
        held = '0;
        forever begin
            @(negedge clk_sys);
            mem_ack = 1'b0;
            if (reset || !mem_req) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = ack_dly;
                    held = {mem_addr, mem_din, mem_be};
                    got_q.push_back(held);
                end else begin
                    chk("req_stable", 64'({mem_addr, mem_din, mem_be}), 64'(held));
                end
                if (ack_en) begin
                    if (wcnt == 0) begin
                        mem_ack = 1'b1;
                        busy    = 1'b0;
                    end else begin
                        wcnt--;
                    end
                end
            end
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge clk_sys);
            if (dl_done === 1'b1) done_cnt++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int addr;
        int n;
        int r;
        int t;

        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        m_have[0]      = 1'b0;
        m_have[1]      = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_req",  64'(mem_req),  64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_din",  64'(mem_din),  64'(0));
        chk("rst_be",   64'(mem_be),   64'(0));
        chk("rst_busy", 64'(dl_busy),  64'(0));
        chk("rst_done", 64'(dl_done),  64'(0));
        chk("rst_ovf",  64'(overflow), 64'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);

        // four sequential bytes, with request latency measured on the completing byte
        ack_dly = 2;
        dl_start();
        repeat (2) @(negedge clk_sys);
        chk("t1_busy", 64'(dl_busy), 64'(1));
        send_byte(32'h150000, 8'hAA, 3);
        @(negedge clk_sys);
        ioctl_addr = 25'h150001;
        ioctl_dout = 8'hBB;
        ioctl_wr   = 1'b1;
        m_byte_in(32'h150001, 8'hBB);
        @(posedge clk_sys);
        #1;
        ioctl_wr = 1'b0;
        chk("t1_lat_n", 64'(mem_req), 64'(0));
        @(posedge clk_sys);
        #1;
        chk("t1_lat_n1", 64'(mem_req), 64'(1));
        send_byte(32'h150002, 8'hCC, 3);
        send_byte(32'h150003, 8'hDD, 3);
        dl_end();
        wait_got("t1", 2);
        if (got_q.size() >= 2) begin
            chk("t1_w0", 64'(got_q[0]), 64'({24'h0A8000, 16'hBBAA, 2'b11}));
            chk("t1_w1", 64'(got_q[1]), 64'({24'h0A8001, 16'hDDCC, 2'b11}));
        end
        drain("t1");
        chk("t1_done", 64'(done_cnt), 64'(1));
        chk("t1_idle", 64'(dl_busy), 64'(0));

        // three bytes, partial last word flushed when download falls
        dl_start();
        send_byte(32'h200000, 8'h11, 2);
        send_byte(32'h200001, 8'h22, 2);
        send_byte(32'h200002, 8'h33, 2);
        dl_end();
        wait_got("t2", 2);
        if (got_q.size() >= 2) begin
            chk("t2_partial", 64'(got_q[1]), 64'({24'h100001, 16'h0033, 2'b01}));
        end
        drain("t2");
        chk("t2_done", 64'(done_cnt), 64'(1));

        // odd byte first, then even byte of the same word
        dl_start();
        send_byte(5, 8'h55, 2);
        send_byte(4, 8'h44, 2);
        dl_end();
        wait_got("t3", 1);
        if (got_q.size() >= 1) begin
            chk("t3_word", 64'(got_q[0]), 64'({24'h000002, 16'h5544, 2'b11}));
        end
        drain("t3");

        // two unrelated even bytes give two partial words
        dl_start();
        send_byte(32'h10, 8'hA1, 2);
        send_byte(32'h20, 8'hB2, 2);
        dl_end();
        wait_got("t4", 2);
        if (got_q.size() >= 2) begin
            chk("t4_w0", 64'(got_q[0]), 64'({24'h000008, 16'h00A1, 2'b01}));
            chk("t4_w1", 64'(got_q[1]), 64'({24'h000010, 16'h00B2, 2'b01}));
        end
        drain("t4");

        // overflow: controller stalls, six words arrive, the sixth is dropped
        ack_en = 1'b0;
        dl_start();
        for (int i = 0; i < 12; i++) begin
            send_byte(32'h1000 + i, 8'(i + 1), 1);
        end
        repeat (4) @(negedge clk_sys);
        chk("t5_ovf", 64'(overflow), 64'(1));
        chk("t5_req", 64'(mem_req), 64'(1));
        void'(exp_q.pop_back());
        dl_end();
        dl_start();
        repeat (2) @(negedge clk_sys);
        chk("t5_ovf_clr", 64'(overflow), 64'(0));
        ack_en = 1'b1;
        dl_end();
        drain("t5");
        chk("t5_done", 64'(done_cnt), 64'(1));

        // random downloads: sequential runs, repeated addresses and jumps
        for (int d = 0; d < 6; d++) begin
            ack_dly = $urandom_range(0, 2);
            dl_start();
            addr = $urandom_range(0, 4000);
            n    = $urandom_range(4, 16);
            for (int k = 0; k < n; k++) begin
                send_byte(addr, 8'($urandom), $urandom_range(6, 8));
                r = $urandom_range(0, 9);
                if (r < 7)      addr = addr + 1;
                else if (r < 8) addr = addr;
                else if (r < 9) addr = $urandom_range(0, 32'h1FFFFF0);
                else            addr = (addr > 0) ? addr - 1 : 0;
            end
            dl_end();
            drain("rnd");
            chk("rnd_done", 64'(done_cnt), 64'(1));
            chk("rnd_ovf", 64'(overflow), 64'(0));
        end

        // bytes outside a download are still packed, without a completion pulse
        done_cnt = 0;
        send_byte(32'h40, 8'h12, 2);
        send_byte(32'h41, 8'h34, 2);
        drain("t7");
        chk("t7_nodone", 64'(done_cnt), 64'(0));

        // reset while a request is outstanding
        ack_en = 1'b0;
        dl_start();
        send_byte(32'h300, 8'h5A, 1);
        send_byte(32'h301, 8'hA5, 1);
        t = 0;
        while (!mem_req && t < 100) begin
            @(negedge clk_sys);
            t++;
        end
        chk("t8_req_seen", 64'(mem_req), 64'(1));
        @(negedge clk_sys);
        reset          = 1'b1;
        ioctl_download = 1'b0;
        #1;
        chk("t8_req_drop", 64'(mem_req), 64'(0));
        chk("t8_busy_drop", 64'(dl_busy), 64'(0));
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        repeat (6) @(negedge clk_sys);
        chk("t8_no_req", 64'(mem_req), 64'(0));
        chk("t8_idle", 64'(dl_busy), 64'(0));
        chk("t8_nodone", 64'(done_cnt), 64'(0));
        got_q.delete();
        exp_q.delete();
        m_valid = 1'b0;
        ack_en  = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
